// File: rtl/haar_lift_forward.sv
// Forward integer Haar lifting: pairs raster pixels (even, odd) into detail d = o - e
// and approximation s = e + floor(d/2), with a framing FSM and a two-stage pipeline.
module haar_lift_forward #(
    parameter int PIX_W   = 8,
    parameter int N_PAIRS = 16384
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_in,
    output logic [15:0]      im11,
    output logic [15:0]      im21,
    output logic             data_occur,
    output logic             frame_done,
    output logic             busy
);

    localparam int CNT_W = $clog2(N_PAIRS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EVEN,
        S_ODD,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PIX_W-1:0]   e_q, e_d;

    // Launch registers: the accepted pair waits here for one cycle.
    logic [PIX_W-1:0]   l_e_q, l_e_d;
    logic [PIX_W-1:0]   l_o_q, l_o_d;
    logic               l_v_q, l_v_d;
    logic               l_last_q, l_last_d;

    logic [15:0]        d1_q, d1_d;
    logic [15:0]        e1_q, e1_d;
    logic               v1_q, v1_d;
    logic               last1_q, last1_d;

    logic [15:0]        im11_q, im11_d;
    logic [15:0]        im21_q, im21_d;
    logic               occur_q, occur_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic signed [15:0] half_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        e_d      = e_q;
        l_e_d    = l_e_q;
        l_o_d    = l_o_q;
        l_v_d    = 1'b0;
        l_last_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_EVEN;
            end
            S_EVEN: begin
                if (!start) begin
                    state_d = S_IDLE;
                    e_d     = '0;
                    cnt_d   = '0;
                end else if (pix_valid) begin
                    e_d     = pix_in;
                    state_d = S_ODD;
                end
            end
            S_ODD: begin
                if (!start) begin
                    state_d = S_IDLE;
                    e_d     = '0;
                    cnt_d   = '0;
                end else if (pix_valid) begin
                    l_e_d = e_q;
                    l_o_d = pix_in;
                    l_v_d = 1'b1;
                    if (cnt_q == CNT_W'(N_PAIRS - 1)) begin
                        l_last_d = 1'b1;
                        cnt_d    = '0;
                        state_d  = S_DONE;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = S_EVEN;
                    end
                end
            end
            default: begin
                if (!start) state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_EVEN) || (state_d == S_ODD);

        // Stage 1: zero-extend both pixels so the 16-bit difference carries the sign.
        v1_d    = l_v_q;
        last1_d = l_v_q & l_last_q;
        d1_d    = d1_q;
        e1_d    = e1_q;
        if (l_v_q) begin
            d1_d = 16'(l_o_q) - 16'(l_e_q);
            e1_d = 16'(l_e_q);
        end

        // Stage 2: shift kept in its own signed assignment so it stays arithmetic.
        half_d  = $signed(d1_q) >>> 1;
        occur_d = v1_q;
        done_d  = v1_q & last1_q;
        im11_d  = im11_q;
        im21_d  = im21_q;
        if (v1_q) begin
            im11_d = d1_q;
            im21_d = e1_q + half_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            e_q      <= '0;
            l_e_q    <= '0;
            l_o_q    <= '0;
            l_v_q    <= 1'b0;
            l_last_q <= 1'b0;
            d1_q     <= '0;
            e1_q     <= '0;
            v1_q     <= 1'b0;
            last1_q  <= 1'b0;
            im11_q   <= '0;
            im21_q   <= '0;
            occur_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            e_q      <= e_d;
            l_e_q    <= l_e_d;
            l_o_q    <= l_o_d;
            l_v_q    <= l_v_d;
            l_last_q <= l_last_d;
            d1_q     <= d1_d;
            e1_q     <= e1_d;
            v1_q     <= v1_d;
            last1_q  <= last1_d;
            im11_q   <= im11_d;
            im21_q   <= im21_d;
            occur_q  <= occur_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign im11       = im11_q;
    assign im21       = im21_q;
    assign data_occur = occur_q;
    assign frame_done = done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_haar_lift_forward.sv
// Scoreboard bench for haar_lift_forward with 4-pair frames: expected pairs are queued
// at acceptance and checked (value, latency, frame_done, inverse lifting) on output.
module tb_haar_lift_forward;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_in = '0;
    logic [15:0] im11;
    logic [15:0] im21;
    logic        data_occur;
    logic        frame_done;
    logic        busy;

    typedef struct {
        logic [15:0] d;
        logic [15:0] s;
        bit          last;
        int          cyc;
        int          e;
        int          o;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [15:0] hold_d = '0;
    logic [15:0] hold_s = '0;

    haar_lift_forward #(.PIX_W(8), .N_PAIRS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pix_valid  (pix_valid),
        .pix_in     (pix_in),
        .im11       (im11),
        .im21       (im21),
        .data_occur (data_occur),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // One clock step: check outputs at the falling edge, return 1ns after the next rising edge.
    task automatic tick();
        exp_t x;
        int   dd, ss, er, orr;
        @(negedge clk);
        if (data_occur === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output cyc=%0d im11=%h im21=%h", cyc, im11, im21);
            end else begin
                x = sb.pop_front();
                if (im11 !== x.d || im21 !== x.s || frame_done !== x.last || cyc != x.cyc) begin
                    bad++;
                    $display("FAIL pair_out e=%0d o=%0d got im11=%h im21=%h fd=%b cyc=%0d exp im11=%h im21=%h fd=%b cyc=%0d",
                             x.e, x.o, im11, im21, frame_done, cyc, x.d, x.s, x.last, x.cyc);
                end
                dd  = $signed(im11);
                ss  = $signed(im21);
                er  = ss - (dd >>> 1);
                orr = er + dd;
                total++;
                if (er != x.e || orr != x.o) begin
                    bad++;
                    $display("FAIL inverse got e=%0d o=%0d exp e=%0d o=%0d", er, orr, x.e, x.o);
                end
                hold_d = x.d;
                hold_s = x.s;
            end
        end else begin
            total++;
            if (im11 !== hold_d || im21 !== hold_s || frame_done !== 1'b0) begin
                bad++;
                $display("FAIL idle_hold got im11=%h im21=%h fd=%b exp im11=%h im21=%h fd=0",
                         im11, im21, frame_done, hold_d, hold_s);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_pair(input logic [7:0] e, input logic [7:0] o, input int gap, input bit last);
        exp_t x;
        int   dd;
        pix_valid = 1'b0;
        repeat (gap) tick();
        pix_in    = e;
        pix_valid = 1'b1;
        tick();
        pix_in = o;
        tick();
        dd     = int'(o) - int'(e);
        x.d    = dd[15:0];
        x.s    = 16'(int'(e) + (dd >>> 1));
        x.last = last;
        x.cyc  = cyc + 2;
        x.e    = int'(e);
        x.o    = int'(o);
        sb.push_back(x);
        pix_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && sb.size() > 0; i++) tick();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout pending=%0d exp=0", sb.size());
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #2;
        total++;
        if (im11 !== 16'h0 || im21 !== 16'h0 || data_occur !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs got im11=%h im21=%h occ=%b fd=%b busy=%b exp all 0",
                     im11, im21, data_occur, frame_done, busy);
        end
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_vectors();
        start = 1'b1;
        tick();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_even got=%b exp=1", busy);
        end
        send_pair(8'd100, 8'd50, 0, 1'b0);
        send_pair(8'd10, 8'd13, 0, 1'b0);
        send_pair(8'd255, 8'd0, 0, 1'b0);
        send_pair(8'd0, 8'd255, 0, 1'b1);
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_done got=%b exp=0", busy);
        end
        // Pixels offered in DONE must be ignored.
        pix_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pix_in = 8'($urandom_range(0, 255));
            tick();
        end
        pix_valid = 1'b0;
        drain();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_after_frame got=%b exp=0", busy);
        end
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_restart got=%b exp=1", busy);
        end
        start = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        start = 1'b1;
        tick();
        send_pair(8'd20, 8'd30, 0, 1'b0);
        pix_in    = 8'd40;
        pix_valid = 1'b1;
        tick();
        pix_valid = 1'b0;
        start     = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_abort got=%b exp=0", busy);
        end
        drain();
        tick();
        // Counter must restart from zero: frame_done belongs on the 4th pair.
        start = 1'b1;
        tick();
        send_pair(8'd1, 8'd2, 0, 1'b0);
        send_pair(8'd200, 8'd100, 1, 1'b0);
        send_pair(8'd7, 8'd7, 0, 1'b0);
        send_pair(8'd128, 8'd129, 2, 1'b1);
        drain();
        start = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        tick();
        send_pair(8'd77, 8'd200, 0, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        total++;
        if (im11 !== 16'h0 || im21 !== 16'h0 || data_occur !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_outputs got im11=%h im21=%h occ=%b fd=%b busy=%b exp all 0",
                     im11, im21, data_occur, frame_done, busy);
        end
        sb.delete();
        hold_d = '0;
        hold_s = '0;
        tick();
        tick();
        start = 1'b0;
        reset = 1'b1;
        repeat (6) tick();
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 8; f++) begin
            start = 1'b1;
            tick();
            for (int p = 0; p < 4; p++) begin
                send_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                          (f % 2 == 1) ? int'($urandom_range(0, 2)) : 0, p == 3);
            end
            // start falls while the last pair is still in the pipeline
            start = 1'b0;
            drain();
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
